// File: rtl/pretu_pkg.sv
// Shared definitions for the streaming 4x4 pre-transform: tile size,
// ping-pong bank states and the row/output width helpers.
package pretu_pkg;

    // Tile edge: every tile is N x N elements, every row carries N elements.
    localparam int unsigned N = 4;

    // Life cycle of one ping-pong bank.
    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    // Row-stage result width: one bit of growth over the input element.
    function automatic int unsigned rw_of(input int unsigned dw);
        return dw + 1;
    endfunction

    // Column-stage result width: two bits of growth over the input element.
    function automatic int unsigned ow_of(input int unsigned dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/pretu_1d.sv
// Combinational 1D pre-transform kernel:
//   y0 = a - c, y1 = b + c, y2 = -b + c, y3 = b - d
// Operands are sign-extended by one bit first, so the result never wraps.
module pretu_1d
    import pretu_pkg::*;
#(
    parameter int unsigned W = 16
)(
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic signed [W-1:0] i_c,
    input  logic signed [W-1:0] i_d,
    output logic signed [W:0]   o_y0,
    output logic signed [W:0]   o_y1,
    output logic signed [W:0]   o_y2,
    output logic signed [W:0]   o_y3
);

    logic signed [W:0] w_a;
    logic signed [W:0] w_b;
    logic signed [W:0] w_c;
    logic signed [W:0] w_d;

    assign w_a = {i_a[W-1], i_a};
    assign w_b = {i_b[W-1], i_b};
    assign w_c = {i_c[W-1], i_c};
    assign w_d = {i_d[W-1], i_d};

    assign o_y0 = w_a - w_c;
    assign o_y1 = w_b + w_c;
    assign o_y2 = w_c - w_b;
    assign o_y3 = w_b - w_d;

endmodule

// File: rtl/pretu_stream.sv
// Streaming 4x4 pre-transform Y = B^T * X * B for CH parallel lanes.
// Input rows are row-transformed on entry and written into a ping-pong
// tile buffer; output rows are column-transformed straight out of the
// read bank, one row per beat. A tile may be marked bypass on its row 0,
// in which case X is emitted unchanged (sign-extended).
module pretu_stream
    import pretu_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned CH = 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*N*DW-1:0]       in_row,
    input  logic                     bypass,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*N*(DW+2)-1:0]   out_row,
    output logic                     out_last
);

    localparam int unsigned RW = rw_of(DW);
    localparam int unsigned OW = ow_of(DW);

    // Bank storage: [bank][row][lane][element]
    logic signed [RW-1:0] r_bank [2][N][CH][N];
    logic                 r_bank_byp [2];
    bank_state_e          r_bank_st [2];
    bank_state_e          w_bank_st_nxt [2];

    logic       r_wr_ptr;
    logic       w_wr_ptr_nxt;
    logic [1:0] r_wr_row;
    logic [1:0] w_wr_row_nxt;
    logic       r_wr_byp;
    logic       w_wr_byp_nxt;

    logic       r_rd_ptr;
    logic       w_rd_ptr_nxt;
    logic [1:0] r_rd_row;
    logic [1:0] w_rd_row_nxt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_byp_now;

    logic signed [RW-1:0] w_row_res [CH][N];
    logic signed [RW-1:0] w_row_st  [CH][N];
    logic signed [OW-1:0] w_col     [CH][N][N];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready   = !rst && ((r_bank_st[r_wr_ptr] == BANK_EMPTY) ||
                                 (r_bank_st[r_wr_ptr] == BANK_FILLING));
    assign out_valid  = !rst && ((r_bank_st[r_rd_ptr] == BANK_FULL) ||
                                 (r_bank_st[r_rd_ptr] == BANK_DRAINING));
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign out_last   = out_valid && (r_rd_row == 2'd3);

    // Bypass is sampled live with row 0 and held for rows 1..3.
    assign w_byp_now = (r_wr_row == 2'd0) ? bypass : r_wr_byp;

    // ------------------------------------------------------------------
    // Row stage: one kernel per lane on the incoming row
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_row
        pretu_1d #(.W(DW)) u_row (
            .i_a  (in_row[(c*N+0)*DW +: DW]),
            .i_b  (in_row[(c*N+1)*DW +: DW]),
            .i_c  (in_row[(c*N+2)*DW +: DW]),
            .i_d  (in_row[(c*N+3)*DW +: DW]),
            .o_y0 (w_row_res[c][0]),
            .o_y1 (w_row_res[c][1]),
            .o_y2 (w_row_res[c][2]),
            .o_y3 (w_row_res[c][3])
        );
        // A bypass tile stores raw X (sign-extended) in the same slots,
        // which is what lets it be emitted unchanged later.
        for (genvar j = 0; j < N; j++) begin : g_sel
            assign w_row_st[c][j] = w_byp_now
                ? {in_row[(c*N+j)*DW + DW - 1], in_row[(c*N+j)*DW +: DW]}
                : w_row_res[c][j];
        end
    end

    // ------------------------------------------------------------------
    // Column stage: one kernel per lane and column on the read bank;
    // the output row index picks which kernel output is emitted.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_col_lane
        for (genvar j = 0; j < N; j++) begin : g_col
            pretu_1d #(.W(RW)) u_col (
                .i_a  (r_bank[r_rd_ptr][0][c][j]),
                .i_b  (r_bank[r_rd_ptr][1][c][j]),
                .i_c  (r_bank[r_rd_ptr][2][c][j]),
                .i_d  (r_bank[r_rd_ptr][3][c][j]),
                .o_y0 (w_col[c][j][0]),
                .o_y1 (w_col[c][j][1]),
                .o_y2 (w_col[c][j][2]),
                .o_y3 (w_col[c][j][3])
            );
        end
    end

    // Output row mux: column result, or stored X for a bypass bank; zero when idle.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (r_bank_byp[r_rd_ptr]) begin
                        out_row[(c*N+j)*OW +: OW] =
                            {r_bank[r_rd_ptr][r_rd_row][c][j][RW-1],
                             r_bank[r_rd_ptr][r_rd_row][c][j]};
                    end else begin
                        out_row[(c*N+j)*OW +: OW] = w_col[c][j][r_rd_row];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // Bank life cycle: writes only touch EMPTY/FILLING banks and reads only
    // FULL/DRAINING ones, so both sides can update in the same cycle.
    always_comb begin
        w_bank_st_nxt[0] = r_bank_st[0];
        w_bank_st_nxt[1] = r_bank_st[1];
        if (w_in_fire) begin
            if (r_wr_row == 2'd0) begin
                w_bank_st_nxt[r_wr_ptr] = BANK_FILLING;
            end else if (r_wr_row == 2'd3) begin
                w_bank_st_nxt[r_wr_ptr] = BANK_FULL;
            end
        end
        if (w_out_fire) begin
            if (r_rd_row == 2'd0) begin
                w_bank_st_nxt[r_rd_ptr] = BANK_DRAINING;
            end else if (r_rd_row == 2'd3) begin
                w_bank_st_nxt[r_rd_ptr] = BANK_EMPTY;
            end
        end
    end

    // Write side: row counter, held bypass flag, bank flip after row 3.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_row_nxt = r_wr_row;
        w_wr_byp_nxt = r_wr_byp;
        if (w_in_fire) begin
            w_wr_row_nxt = r_wr_row + 2'd1;
            if (r_wr_row == 2'd0) begin
                w_wr_byp_nxt = bypass;
            end
            if (r_wr_row == 2'd3) begin
                w_wr_ptr_nxt = ~r_wr_ptr;
            end
        end
    end

    // Read side: row counter, bank flip after the last row is taken.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_rd_row_nxt = r_rd_row;
        if (w_out_fire) begin
            w_rd_row_nxt = r_rd_row + 2'd1;
            if (r_rd_row == 2'd3) begin
                w_rd_ptr_nxt = ~r_rd_ptr;
            end
        end
    end

    // Control state registers; reset discards every buffered tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_st[0]  <= BANK_EMPTY;
            r_bank_st[1]  <= BANK_EMPTY;
            r_bank_byp[0] <= 1'b0;
            r_bank_byp[1] <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_wr_row      <= 2'd0;
            r_wr_byp      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_rd_row      <= 2'd0;
        end else begin
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];
            if (w_in_fire && (r_wr_row == 2'd0)) begin
                r_bank_byp[r_wr_ptr] <= bypass;
            end
            r_wr_ptr <= w_wr_ptr_nxt;
            r_wr_row <= w_wr_row_nxt;
            r_wr_byp <= w_wr_byp_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_rd_row <= w_rd_row_nxt;
        end
    end

    // Bank data: only read while the bank is FULL/DRAINING, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    r_bank[r_wr_ptr][r_wr_row][c][j] <= w_row_st[c][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_pretu_stream.sv
// Directed bench for pretu_stream (DW=16, CH=1). Expected rows come from
// hand-computed constants or from a direct B^T*X*B matrix product.
module tb_pretu_stream;

    localparam int DW = 16;
    localparam int CH = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_row;
    logic        bypass;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_row;
    logic        out_last;

    always #5 clk = ~clk;

    pretu_stream #(.DW(DW), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] src_q [$];
    logic        src_b [$];
    logic [71:0] exp_q [$];
    logic        exp_l [$];
    int          tile_x [16];
    int          bt [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [71:0] pk(input int y0, input int y1, input int y2, input int y3);
        logic [71:0] v;
        v[17:0]  = 18'(y0);
        v[35:18] = 18'(y1);
        v[53:36] = 18'(y2);
        v[71:54] = 18'(y3);
        return v;
    endfunction

    task automatic push_src(input logic byp);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) r[j*16 +: 16] = 16'(tile_x[i*4+j]);
            src_q.push_back(r);
            src_b.push_back(byp);
        end
    endtask

    task automatic push_model(input logic byp);
        int y [4];
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (byp) begin
                    y[j] = tile_x[i*4+j];
                end else begin
                    y[j] = 0;
                    for (int k = 0; k < 4; k++)
                        for (int l = 0; l < 4; l++)
                            y[j] += bt[i][k] * tile_x[k*4+l] * bt[j][l];
                end
            end
            exp_q.push_back(pk(y[0], y[1], y[2], y[3]));
            exp_l.push_back(i == 3);
        end
    endtask

    // Drives src_q, checks outputs against exp_q; out_ready low for the first
    // 'stall' cycles. Entered and left just after a rising edge.
    task automatic run(input int stall, input int budget,
                       output int first_out, output int last_in, output int last_out,
                       output int bubbles, output int acc_snap, output logic rdy_snap);
        int          n;
        int          in_idx;
        int          cyc;
        bit          held_v;
        bit          in_fire;
        logic [71:0] held;
        n = src_q.size();
        in_idx = 0; cyc = 0; held_v = 0; held = '0;
        first_out = -1; last_in = -1; last_out = -1; bubbles = 0; acc_snap = -1; rdy_snap = 1'bx;
        in_valid = (n > 0);
        if (n > 0) begin
            in_row = src_q[0];
            bypass = src_b[0];
        end
        out_ready = (stall == 0);
        while ((in_idx < n || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (cyc == stall) begin
                acc_snap = in_idx;
                rdy_snap = in_ready;
            end
            if (held_v) chk("stall_hold", out_row, held);
            held_v = out_valid && !out_ready;
            held   = out_row;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {71'b0, out_valid}, 72'd0);
                end else begin
                    chk("row", out_row, exp_q.pop_front());
                    chk("last", {71'b0, out_last}, {71'b0, exp_l.pop_front()});
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
            end
            in_fire = in_valid && in_ready;
            if (in_valid && !in_ready) bubbles++;
            if (in_fire && in_idx == n - 1) last_in = cyc;
            @(posedge clk);
            #1;
            if (in_fire) in_idx++;
            if (in_idx < n) begin
                in_row = src_q[in_idx];
                bypass = src_b[in_idx];
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
            out_ready = (cyc >= stall);
        end
        if (in_idx < n || exp_q.size() > 0)
            chk("timeout_pending", 72'(n - in_idx + exp_q.size()), 72'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        src_q.delete(); src_b.delete(); exp_q.delete(); exp_l.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   fo, li, lo, bb, acc;
        logic rs;

        rst = 1'b1; in_valid = 1'b0; in_row = '0; bypass = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {71'b0, in_ready}, 72'd0);
        chk("rst_out_valid", {71'b0, out_valid}, 72'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {71'b0, in_ready}, 72'd1);
        chk("post_rst_out_valid", {71'b0, out_valid}, 72'd0);
        chk("post_rst_out_last", {71'b0, out_last}, 72'd0);
        chk("post_rst_out_row", out_row, 72'd0);
        @(posedge clk); #1;

        // Tile 1..16, hand-computed result, latency check
        tile_x = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        push_src(1'b0);
        exp_q.push_back(pk(0, -16, 0, 0));  exp_l.push_back(1'b0);
        exp_q.push_back(pk(-4, 34, 2, -4)); exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, 8, 0, 0));    exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, -16, 0, 0));  exp_l.push_back(1'b1);
        run(0, 100, fo, li, lo, bb, acc, rs);
        chk("s1_last_in_cycle", 72'(li), 72'd3);
        chk("s1_first_out_cycle", 72'(fo), 72'd4);

        // Signed tile against the matrix model
        tile_x = '{-1, 2, -3, 4, 5, -6, 7, -8, -9, 10, -11, 12, 13, -14, 15, -16};
        push_src(1'b0);
        push_model(1'b0);
        run(0, 100, fo, li, lo, bb, acc, rs);

        // Most negative input everywhere: growth without wrap
        for (int i = 0; i < 16; i++) tile_x[i] = -32768;
        push_src(1'b0);
        exp_q.push_back(pk(0, 0, 0, 0));       exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, -131072, 0, 0)); exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, 0, 0, 0));       exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, 0, 0, 0));       exp_l.push_back(1'b1);
        run(0, 100, fo, li, lo, bb, acc, rs);

        // Bypass tile then transform tile, back-to-back
        tile_x = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        push_src(1'b1);
        push_model(1'b1);
        push_src(1'b0);
        exp_q.push_back(pk(0, -16, 0, 0));  exp_l.push_back(1'b0);
        exp_q.push_back(pk(-4, 34, 2, -4)); exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, 8, 0, 0));    exp_l.push_back(1'b0);
        exp_q.push_back(pk(0, -16, 0, 0));  exp_l.push_back(1'b1);
        run(0, 100, fo, li, lo, bb, acc, rs);
        chk("s4_in_bubbles", 72'(bb), 72'd0);
        chk("s4_last_in_cycle", 72'(li), 72'd7);
        chk("s4_out_span", 72'(lo - fo), 72'd7);

        // Three tiles offered with the output stalled for 10 cycles
        tile_x = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        push_src(1'b0); push_model(1'b0);
        tile_x = '{-1, 2, -3, 4, 5, -6, 7, -8, -9, 10, -11, 12, 13, -14, 15, -16};
        push_src(1'b0); push_model(1'b0);
        tile_x = '{7, -7, 100, -200, 0, 1, -1, 32767, -32768, 5, 6, 9, 3, 3, -3, 2};
        push_src(1'b1); push_model(1'b1);
        run(10, 200, fo, li, lo, bb, acc, rs);
        chk("s5_rows_accepted_in_stall", 72'(acc), 72'd8);
        chk("s5_in_ready_in_stall", {71'b0, rs}, 72'd0);

        // One full undrained tile plus a partial tile, then reset
        tile_x = '{9, 9, 9, 9, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
        push_src(1'b0);
        push_src(1'b0);
        void'(src_q.pop_back());
        void'(src_b.pop_back());
        run(1000, 40, fo, li, lo, bb, acc, rs);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {71'b0, out_valid}, 72'd0);
        chk("midrst_in_ready", {71'b0, in_ready}, 72'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        tile_x = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        push_src(1'b0);
        push_model(1'b0);
        run(0, 100, fo, li, lo, bb, acc, rs);
        chk("s6_first_out_cycle", 72'(fo), 72'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
